ysyx_041461_exe_div: RTL and testbench

YSYX_041461_EXE_DIV -- requirements
Module: ysyx_041461_EXE_div

---
 rtl/ysyx_041461_exe_div_pkg.sv | 61 ++++++
 rtl/ysyx_041461_div_step.sv | 19 +
 rtl/ysyx_041461_exe_div.sv | 168 ++++++++++++++++
 tb/tb_ysyx_041461_exe_div.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_exe_div_pkg.sv
// Shared definitions for the 64-bit iterative divider: op encodings, FSM states, step counts
// and the final result selection used on completion.
package ysyx_041461_exe_div_pkg;

  localparam logic [2:0] OpDiv   = 3'd0;
  localparam logic [2:0] OpDivu  = 3'd1;
  localparam logic [2:0] OpRem   = 3'd2;
  localparam logic [2:0] OpRemu  = 3'd3;
  localparam logic [2:0] OpDivw  = 3'd4;
  localparam logic [2:0] OpDivuw = 3'd5;
  localparam logic [2:0] OpRemw  = 3'd6;
  localparam logic [2:0] OpRemuw = 3'd7;

  localparam int unsigned DivIters  = 64;
  localparam int unsigned DivWIters = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  function automatic logic op_is_w(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] val);
    return {{32{val[31]}}, val};
  endfunction

  // Applies signs and the divide-by-zero / overflow overrides to the raw magnitudes.
  function automatic logic [63:0] final_result(input logic [2:0]  op,
                                               input logic [63:0] quot,
                                               input logic [63:0] rem,
                                               input logic [63:0] src1,
                                               input logic        q_neg,
                                               input logic        r_neg,
                                               input logic        div_zero,
                                               input logic        ovf);
    logic [63:0] val;
    if (op_is_rem(op)) begin
      if (div_zero)  val = src1;
      else if (ovf)  val = '0;
      else           val = r_neg ? -rem : rem;
    end else begin
      if (div_zero)  val = '1;
      else if (ovf)  val = src1;
      else           val = q_neg ? -quot : quot;
    end
    return op_is_w(op) ? sext32(val[31:0]) : val;
  endfunction

endpackage

// File: rtl/ysyx_041461_div_step.sv
// One combinational radix-2 restoring division step.
module ysyx_041461_div_step (
  input  logic [63:0] part_rem,
  input  logic [63:0] divisor,
  input  logic        next_bit,
  output logic [63:0] new_rem,
  output logic        q_bit
);

  logic [64:0] shifted;
  logic [63:0] diff;

  assign shifted = {part_rem, next_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the difference is below the divisor, so 64 bits suffice.
  assign diff    = shifted[63:0] - divisor;
  assign new_rem = q_bit ? diff : shifted[63:0];

endmodule

// File: rtl/ysyx_041461_exe_div.sv
// 64-bit iterative restoring divider for the EXE stage (DIV/REM and W variants).
// Define YSYX_041461_DIV_FAST_SPECIAL_EN to finish divide-by-zero and overflow in one cycle.
module ysyx_041461_exe_div
  import ysyx_041461_exe_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid_in,
  input  logic [2:0]  div_op_in,
  input  logic [63:0] div_src1_in,
  input  logic [63:0] div_src2_in,
  input  logic        div_flush,
  output logic        div_ready_out,
  output logic        div_busy_out,
  output logic        div_done_out,
  output logic [63:0] div_result_out
);

  div_state_e  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] src1_q, src1_d;
  logic [63:0] dvd_q, dvd_d;
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] result_q, result_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic        in_w, in_signed, neg_a, neg_b, in_zero, in_ovf;
  logic [63:0] in_a, in_b, mag_a, mag_b;
  logic [63:0] step_rem;
  logic        step_q;
  logic        last_step;

  assign in_w      = op_is_w(div_op_in);
  assign in_signed = op_is_signed(div_op_in);

  always_comb begin
    in_a = div_src1_in;
    in_b = div_src2_in;
    if (in_w) begin
      in_a = in_signed ? sext32(div_src1_in[31:0]) : {32'b0, div_src1_in[31:0]};
      in_b = in_signed ? sext32(div_src2_in[31:0]) : {32'b0, div_src2_in[31:0]};
    end
  end

  assign neg_a   = in_signed & in_a[63];
  assign neg_b   = in_signed & in_b[63];
  assign mag_a   = neg_a ? -in_a : in_a;
  assign mag_b   = neg_b ? -in_b : in_b;
  assign in_zero = in_w ? (div_src2_in[31:0] == 32'd0) : (div_src2_in == 64'd0);
  assign in_ovf  = in_signed &&
                   (in_w ? (div_src1_in[31:0] == 32'h8000_0000 && div_src2_in[31:0] == '1)
                         : (div_src1_in == {1'b1, 63'b0} && div_src2_in == '1));

  ysyx_041461_div_step u_step (
    .part_rem (rem_q),
    .divisor  (dvs_q),
    .next_bit (dvd_q[63]),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  assign last_step = (cnt_q == (op_is_w(op_q) ? 7'(DivWIters - 1) : 7'(DivIters - 1)));

  assign div_ready_out  = (state_q == StIdle) || (state_q == StDone);
  assign div_busy_out   = (state_q == StCalc) ||
                          (state_q == StIdle && div_valid_in && !div_flush);
  assign div_done_out   = (state_q == StDone);
  assign div_result_out = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    src1_d   = src1_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    if (div_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (div_valid_in) begin
            op_d    = div_op_in;
            src1_d  = div_src1_in;
            // W dividends are left-aligned so the same MSB-first shift serves both widths.
            dvd_d   = in_w ? {mag_a[31:0], 32'b0} : mag_a;
            dvs_d   = mag_b;
            rem_d   = '0;
            q_neg_d = neg_a ^ neg_b;
            r_neg_d = neg_a;
            zero_d  = in_zero;
            ovf_d   = in_ovf;
            cnt_d   = '0;
`ifdef YSYX_041461_DIV_FAST_SPECIAL_EN
            if (in_zero || in_ovf) begin
              state_d  = StDone;
              result_d = final_result(div_op_in, '0, '0, div_src1_in, 1'b0, 1'b0,
                                      in_zero, in_ovf);
            end else begin
              state_d = StCalc;
            end
`else
            state_d = StCalc;
`endif
          end else if (state_q == StDone) begin
            state_d = StIdle;
          end
        end
        StCalc: begin
          dvd_d = {dvd_q[62:0], step_q};
          rem_d = step_rem;
          cnt_d = cnt_q + 7'd1;
          if (last_step) begin
            state_d  = StDone;
            cnt_d    = '0;
            result_d = final_result(op_q, {dvd_q[62:0], step_q}, step_rem, src1_q,
                                    q_neg_q, r_neg_q, zero_q, ovf_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      src1_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_exe_div.sv
// Self-checking bench for ysyx_041461_exe_div: directed table, corner sequences, random ops.
module tb_ysyx_041461_exe_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid_in;
  logic [2:0]  div_op_in;
  logic [63:0] div_src1_in;
  logic [63:0] div_src2_in;
  logic        div_flush;
  logic        div_ready_out;
  logic        div_busy_out;
  logic        div_done_out;
  logic [63:0] div_result_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_041461_exe_div dut (
    .clk            (clk),
    .rst            (rst),
    .div_valid_in   (div_valid_in),
    .div_op_in      (div_op_in),
    .div_src1_in    (div_src1_in),
    .div_src2_in    (div_src2_in),
    .div_flush      (div_flush),
    .div_ready_out  (div_ready_out),
    .div_busy_out   (div_busy_out),
    .div_done_out   (div_done_out),
    .div_result_out (div_result_out)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        special;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic               is_w   = op[2];
    logic               sgn    = !op[0];
    logic               is_rem = op[1];
    logic signed [63:0] sa     = a;
    logic signed [63:0] sb     = b;
    logic signed [31:0] sa32   = a[31:0];
    logic signed [31:0] sb32   = b[31:0];
    logic        [31:0] r32;
    logic        [63:0] r;
    if (is_w) begin
      if (b[31:0] == 32'd0) r32 = is_rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = is_rem ? 32'd0 : a[31:0];
      else if (sgn) begin
        if (is_rem) r32 = sa32 % sb32;
        else        r32 = sa32 / sb32;
      end else begin
        if (is_rem) r32 = a[31:0] % b[31:0];
        else        r32 = a[31:0] / b[31:0];
      end
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) r = is_rem ? a : '1;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = is_rem ? 64'd0 : a;
      else if (sgn) begin
        if (is_rem) r = sa % sb;
        else        r = sa / sb;
      end else begin
        if (is_rem) r = a % b;
        else        r = a / b;
      end
    end
    return r;
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [63:0] a,
                                      input logic [63:0] b);
    if (op[2])
      return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic special);
`ifdef YSYX_041461_DIV_FAST_SPECIAL_EN
    if (special) return 1;
`endif
    return op[2] ? 33 : 65;
  endfunction

  // Called just after an accept edge; lat counts edges from the accept edge to done.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (div_done_out) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    div_valid_in = 1'b1;
    div_op_in    = op;
    div_src1_in  = a;
    div_src2_in  = b;
    @(posedge clk);
    #1 div_valid_in = 1'b0;
    wait_done(lat);
    res = div_result_out;
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_done_out) seen++;
    end
  endtask

  vec_t        vecs[15];
  logic [63:0] res, prev;
  int          lat, seen;

  initial begin
    vecs[0]  = '{3'd1, 64'd100, 64'd7, 64'd14, 1'b0};
    vecs[1]  = '{3'd3, 64'd100, 64'd7, 64'd2, 1'b0};
    vecs[2]  = '{3'd0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[3]  = '{3'd2, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[5]  = '{3'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6]  = '{3'd2, 64'd5, 64'd0, 64'd5, 1'b1};
    vecs[7]  = '{3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1'b1};
    vecs[8]  = '{3'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
    vecs[9]  = '{3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0};
    vecs[10] = '{3'd6, 64'h0000_0000_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[11] = '{3'd7, 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_FFFF_FFF0, 64'hF, 1'b0};
    vecs[12] = '{3'd5, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[13] = '{3'd1, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[14] = '{3'd6, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_8000_0001, 1'b1};

    rst          = 1'b0;
    div_valid_in = 1'b0;
    div_op_in    = '0;
    div_src1_in  = '0;
    div_src2_in  = '0;
    div_flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", div_done_out, 0);
    check("rst_busy", div_busy_out, 0);
    check("rst_result", div_result_out, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rel_ready", div_ready_out, 1);
    check("rel_busy", div_busy_out, 0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_res", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].op, vecs[i].special));
      check($sformatf("vec%0d_ready", i), div_ready_out, 1);
      check($sformatf("vec%0d_busy", i), div_busy_out, 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pulse", i), div_done_out, 0);
      check($sformatf("vec%0d_hold", i), div_result_out, vecs[i].exp);
    end
    prev = div_result_out;

    // Busy is raised in the IDLE request cycle; ready drops in CALC
    @(negedge clk);
    div_valid_in = 1'b1;
    div_op_in    = 3'd1;
    div_src1_in  = 64'd1000;
    div_src2_in  = 64'd3;
    #1 check("idle_req_busy", div_busy_out, 1);
    @(posedge clk);
    #1 div_valid_in = 1'b0;
    check("calc_ready", div_ready_out, 0);
    check("calc_busy", div_busy_out, 1);
    // Flush at CALC cycle 10
    repeat (9) @(posedge clk);
    @(negedge clk) div_flush = 1'b1;
    @(posedge clk);
    #1 div_flush = 1'b0;
    check("flush_ready", div_ready_out, 1);
    check("flush_busy", div_busy_out, 0);
    check("flush_done", div_done_out, 0);
    check("flush_hold", div_result_out, prev);
    run_op(3'd3, 64'd1000, 64'd7, res, lat);
    check("post_flush_res", res, 64'd6);
    check("post_flush_lat", lat, 65);

    // Flush with a request in the same cycle: nothing accepted
    @(negedge clk);
    div_valid_in = 1'b1;
    div_flush    = 1'b1;
    div_op_in    = 3'd0;
    div_src1_in  = 64'd50;
    div_src2_in  = 64'd5;
    #1 check("flush_valid_busy", div_busy_out, 0);
    @(posedge clk);
    #1;
    div_valid_in = 1'b0;
    div_flush    = 1'b0;
    check("flush_valid_ready", div_ready_out, 1);
    count_done(80, seen);
    check("flush_valid_nodone", seen, 0);

    // Back-to-back: request B held through CALC of A, accepted in A's done cycle
    @(negedge clk);
    div_valid_in = 1'b1;
    div_op_in    = 3'd1;
    div_src1_in  = 64'd81;
    div_src2_in  = 64'd9;
    @(posedge clk);
    #1;
    div_op_in    = 3'd0;
    div_src1_in  = -64'sd100;
    div_src2_in  = 64'd7;
    wait_done(lat);
    check("b2b_a_res", div_result_out, 64'd9);
    check("b2b_a_lat", lat, 65);
    check("b2b_done_ready", div_ready_out, 1);
    check("b2b_done_busy", div_busy_out, 0);
    @(posedge clk);
    #1 div_valid_in = 1'b0;
    check("b2b_accept_ready", div_ready_out, 0);
    check("b2b_accept_done", div_done_out, 0);
    wait_done(lat);
    check("b2b_b_res", div_result_out, 64'hFFFF_FFFF_FFFF_FFF2);
    check("b2b_b_lat", lat, 65);

    // Reset in the middle of CALC
    @(negedge clk);
    div_valid_in = 1'b1;
    div_op_in    = 3'd1;
    div_src1_in  = 64'd77;
    div_src2_in  = 64'd5;
    @(posedge clk);
    #1 div_valid_in = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("midrst_done", div_done_out, 0);
    check("midrst_busy", div_busy_out, 0);
    check("midrst_result", div_result_out, 0);
    @(negedge clk) rst = 1'b1;
    #1 check("midrst_ready", div_ready_out, 1);
    count_done(80, seen);
    check("midrst_nodone", seen, 0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [63:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: ;
        1: b = 64'($urandom_range(1, 20));
        2: b = {$urandom(), 32'd0} & (op[2] ? 64'hFFFF_FFFF_0000_0000 : 64'd0);
        3: begin
          a = op[2] ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = op[2] ? {$urandom(), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        4: b = {32'd0, $urandom()};
        default: b = -64'($urandom_range(1, 300));
      endcase
      run_op(op, a, b, res, lat);
      check($sformatf("rand%0d_op%0d_res", i, op), res, ref_model(op, a, b));
      check($sformatf("rand%0d_op%0d_lat", i, op), lat, exp_lat(op, is_special(op, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
